// File: rtl/cmd_sequencer_pkg.sv
// Shared command/engine encodings, queue entry layout and FSM state type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cmd_sequencer_pkg;

    // Command codes from the button command generator
    localparam logic [2:0] CMD_IDLE      = 3'd0;
    localparam logic [2:0] CMD_SEED      = 3'd1;
    localparam logic [2:0] CMD_ADVANCE   = 3'd2;
    localparam logic [2:0] CMD_READ_CELL = 3'd3;

    // Engine operation encodings
    localparam logic [1:0] ENG_OP_STEP = 2'd0;
    localparam logic [1:0] ENG_OP_SEED = 2'd1;
    localparam logic [1:0] ENG_OP_READ = 2'd2;

    // Queue entry: {cmd, arg0}
    localparam int ENTRY_W = 35;

    typedef struct packed {
        logic [2:0]  cmd;
        logic [31:0] arg;
    } entry_t;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_e;

    // Commands that occupy a queue slot; everything else except IDLE is dropped
    function automatic logic is_queued_cmd(input logic [2:0] c);
        return (c == CMD_SEED) || (c == CMD_ADVANCE) || (c == CMD_READ_CELL);
    endfunction

    function automatic logic [1:0] op_of(input logic [2:0] c);
        logic [1:0] op;
        op = ENG_OP_STEP;
        if (c == CMD_SEED)      op = ENG_OP_SEED;
        if (c == CMD_READ_CELL) op = ENG_OP_READ;
        return op;
    endfunction

endpackage

// File: rtl/cmd_sequencer_fifo.sv
// Synchronous FIFO with flush; head visible combinationally on dout_o.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: push is dropped when full unless a pop happens in the same cycle.
module cmd_fifo
    import cmd_sequencer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = ENTRY_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             empty_nxt_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign dout_o  = mem_q[rptr_q[AW-1:0]];

    // A pop in the same cycle frees the slot a push on full needs
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Pointer next-state; flush wins over everything
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + 1'b1;
            if (do_pop)  rptr_d = rptr_q + 1'b1;
        end
    end

    assign empty_nxt_o = (wptr_d == rptr_d);

    // Pointer registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wptr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/cmd_sequencer.sv
// Queues button commands and expands them into engine ops (ADVANCE N -> N steps); IDLE aborts.
// Latency: cmd_valid at edge t into an idle, empty sequencer gives eng_valid after edge t+2.
// Backpressure: none upstream (full queue drops and sets overflow); eng_ready stalls issue.
// Optional feature macro: CMD_SEQ_GEN_COUNT_EN builds the gen_count counter (else tied to 0).
module cmd_sequencer
    import cmd_sequencer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  cmd,
    input  logic [31:0] cmd_arg0,
    input  logic        cmd_valid,
    output logic [1:0]  eng_op,
    output logic [31:0] eng_arg,
    output logic        eng_valid,
    input  logic        eng_ready,
    output logic        busy,
    output logic        overflow,
    output logic [31:0] gen_count
);

    state_e      state_q, state_d;
    logic        eng_valid_q, eng_valid_d;
    logic [1:0]  eng_op_q, eng_op_d;
    logic [31:0] eng_arg_q, eng_arg_d;
    logic [31:0] remaining_q, remaining_d;
    logic        fetch_vld_q, fetch_vld_d;
    entry_t      fetch_q, fetch_d;
    logic        busy_q, busy_d;
    logic        overflow_q, overflow_d;

    logic        abort;
    logic        push;
    logic        pop;
    logic        hs;
    logic        fetch_retire;
    entry_t      push_entry;
    entry_t      head;
    logic [ENTRY_W-1:0] fifo_dout;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_empty_nxt;

    assign abort        = cmd_valid && (cmd == CMD_IDLE);
    assign push         = cmd_valid && is_queued_cmd(cmd);
    assign hs           = eng_valid_q && eng_ready;
    assign push_entry   = '{cmd: cmd, arg: cmd_arg0};
    assign head         = fifo_dout;
    // ADVANCE 0 dies in the fetch slot without ever reaching the engine
    assign fetch_retire = fetch_vld_q && (fetch_q.cmd == CMD_ADVANCE) && (fetch_q.arg == '0);

    cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush_i     (abort),
        .push_i      (push),
        .din_i       (push_entry),
        .pop_i       (pop),
        .dout_o      (fifo_dout),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .empty_nxt_o (fifo_empty_nxt)
    );

    // Pop into the fetch slot when idle with a free slot, or on the last handshake of a command
    always_comb begin
        pop = 1'b0;
        if (!abort && !fifo_empty) begin
            if (state_q == S_IDLE) pop = !fetch_vld_q || fetch_retire;
            else                   pop = hs && (remaining_q <= 32'd1);
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        eng_valid_d = eng_valid_q;
        eng_op_d    = eng_op_q;
        eng_arg_d   = eng_arg_q;
        remaining_d = remaining_q;
        fetch_vld_d = fetch_vld_q;
        fetch_d     = fetch_q;
        overflow_d  = overflow_q;

        case (state_q)
            S_IDLE: begin
                if (fetch_vld_q && !fetch_retire && !abort) begin
                    state_d     = S_ISSUE;
                    eng_valid_d = 1'b1;
                    eng_op_d    = op_of(fetch_q.cmd);
                    eng_arg_d   = (fetch_q.cmd == CMD_ADVANCE) ? 32'd0 : fetch_q.arg;
                    remaining_d = (fetch_q.cmd == CMD_ADVANCE) ? fetch_q.arg : 32'd0;
                end
            end
            S_ISSUE: begin
                if (hs) begin
                    if (!abort && (remaining_q > 32'd1)) begin
                        remaining_d = remaining_q - 32'd1;
                    end else begin
                        state_d     = S_IDLE;
                        eng_valid_d = 1'b0;
                        remaining_d = '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Fetch slot: always drained when idle, refilled by a pop
        if (abort) begin
            fetch_vld_d = 1'b0;
        end else if (pop) begin
            fetch_vld_d = 1'b1;
            fetch_d     = head;
        end else if (state_q == S_IDLE) begin
            fetch_vld_d = 1'b0;
        end

        // Abort leaves an in-flight op offered but stops any further steps
        if (abort) begin
            remaining_d = '0;
            overflow_d  = 1'b0;
        end else if (push && fifo_full && !pop) begin
            overflow_d  = 1'b1;
        end
    end

    assign busy_d = !fifo_empty_nxt || fetch_vld_d || (state_d == S_ISSUE);

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            eng_valid_q <= 1'b0;
            eng_op_q    <= ENG_OP_STEP;
            eng_arg_q   <= '0;
            remaining_q <= '0;
            fetch_vld_q <= 1'b0;
            fetch_q     <= '0;
            busy_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            eng_valid_q <= eng_valid_d;
            eng_op_q    <= eng_op_d;
            eng_arg_q   <= eng_arg_d;
            remaining_q <= remaining_d;
            fetch_vld_q <= fetch_vld_d;
            fetch_q     <= fetch_d;
            busy_q      <= busy_d;
            overflow_q  <= overflow_d;
        end
    end

`ifdef CMD_SEQ_GEN_COUNT_EN
    logic [31:0] gen_count_q;

    // Count completed steps; a completed seed restarts the count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gen_count_q <= '0;
        end else if (hs) begin
            if (eng_op_q == ENG_OP_STEP)      gen_count_q <= gen_count_q + 32'd1;
            else if (eng_op_q == ENG_OP_SEED) gen_count_q <= '0;
        end
    end

    assign gen_count = gen_count_q;
`else
    assign gen_count = '0;
`endif

    assign eng_valid = eng_valid_q;
    assign eng_op    = eng_op_q;
    assign eng_arg   = eng_arg_q;
    assign busy      = busy_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_cmd_sequencer.sv
// Directed bench for cmd_sequencer: seed, multi-step advance, advance 0, overflow/abort, reset.
module tb_cmd_sequencer;
    import cmd_sequencer_pkg::*;

`ifdef CMD_SEQ_GEN_COUNT_EN
    localparam bit GEN_EN = 1'b1;
`else
    localparam bit GEN_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  cmd = '0;
    logic [31:0] cmd_arg0 = '0;
    logic        cmd_valid = 1'b0;
    logic [1:0]  eng_op;
    logic [31:0] eng_arg;
    logic        eng_valid;
    logic        eng_ready = 1'b0;
    logic        busy;
    logic        overflow;
    logic [31:0] gen_count;

    cmd_sequencer #(.DEPTH(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd       (cmd),
        .cmd_arg0  (cmd_arg0),
        .cmd_valid (cmd_valid),
        .eng_op    (eng_op),
        .eng_arg   (eng_arg),
        .eng_valid (eng_valid),
        .eng_ready (eng_ready),
        .busy      (busy),
        .overflow  (overflow),
        .gen_count (gen_count)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Handshake monitor: values at the falling edge are what the next rising edge samples
    int          hs_cnt = 0;
    int          step_cnt = 0;
    int          read_cnt = 0;
    logic [1:0]  last_op = '0;
    logic [31:0] last_arg = '0;
    always @(negedge clk) begin
        if (reset_n && eng_valid && eng_ready) begin
            hs_cnt   <= hs_cnt + 1;
            if (eng_op == ENG_OP_STEP) step_cnt <= step_cnt + 1;
            if (eng_op == ENG_OP_READ) read_cnt <= read_cnt + 1;
            last_op  <= eng_op;
            last_arg <= eng_arg;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one command for one edge; returns #1 after that edge
    task automatic send(input logic [2:0] c, input logic [31:0] a);
        cmd       = c;
        cmd_arg0  = a;
        cmd_valid = 1'b1;
        tick(1);
        cmd_valid = 1'b0;
        cmd       = CMD_IDLE;
        cmd_arg0  = '0;
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_eng_valid"}, eng_valid, 0);
        chk({pfx, "_eng_op"},    eng_op,    ENG_OP_STEP);
        chk({pfx, "_eng_arg"},   eng_arg,   0);
        chk({pfx, "_busy"},      busy,      0);
        chk({pfx, "_overflow"},  overflow,  0);
        chk({pfx, "_gen_count"}, gen_count, 0);
    endtask

    initial begin
        int  s0, r0, h0, gaps;
        bit  seen, got;

        // Reset state
        tick(2);
        chk_reset_vals("rst");
        reset_n = 1'b1;
        tick(1);

        // SEED 0xcafebabe: valid rises two edges after the command edge
        eng_ready = 1'b1;
        h0 = hs_cnt;
        send(CMD_SEED, 32'hcafebabe);
        chk("seed_valid_t0", eng_valid, 0);
        chk("seed_busy_t0", busy, 1);
        tick(1);
        chk("seed_valid_t1", eng_valid, 0);
        tick(1);
        chk("seed_valid_t2", eng_valid, 1);
        chk("seed_op", eng_op, ENG_OP_SEED);
        chk("seed_arg", eng_arg, 32'hcafebabe);
        tick(4);
        chk("seed_hs_count", hs_cnt - h0, 1);
        chk("seed_gen_count", gen_count, 0);
        chk("seed_busy_end", busy, 0);

        // ADVANCE 3 with ready toggling: three steps, valid never drops in between
        eng_ready = 1'b0;
        s0 = step_cnt;
        gaps = 0;
        seen = 1'b0;
        send(CMD_ADVANCE, 32'd3);
        for (int i = 0; i < 20; i++) begin
            eng_ready = ~eng_ready;
            tick(1);
            if (eng_valid) seen = 1'b1;
            if (seen && !eng_valid && (step_cnt - s0) < 3) gaps++;
        end
        eng_ready = 1'b1;
        chk("adv3_steps", step_cnt - s0, 3);
        chk("adv3_no_gap", gaps, 0);
        chk("adv3_gen_count", gen_count, GEN_EN ? 3 : 0);
        chk("adv3_busy_end", busy, 0);
        chk("adv3_valid_end", eng_valid, 0);

        // ADVANCE 0 then READ_CELL 0x10: no step, one read
        s0 = step_cnt;
        r0 = read_cnt;
        send(CMD_ADVANCE, 32'd0);
        send(CMD_READ_CELL, 32'h10);
        tick(8);
        chk("adv0_no_step", step_cnt - s0, 0);
        chk("adv0_read_cnt", read_cnt - r0, 1);
        chk("adv0_read_op", last_op, ENG_OP_READ);
        chk("adv0_read_arg", last_arg, 32'h10);
        chk("adv0_busy_end", busy, 0);

        // Stalled engine: one in flight, four queued, sixth command overflows
        eng_ready = 1'b0;
        h0 = hs_cnt;
        send(CMD_SEED, 32'd1);
        send(CMD_READ_CELL, 32'd2);
        send(CMD_READ_CELL, 32'd3);
        send(CMD_READ_CELL, 32'd4);
        send(CMD_READ_CELL, 32'd5);
        chk("ovf_before_6th", overflow, 0);
        send(CMD_READ_CELL, 32'd6);
        chk("ovf_after_6th", overflow, 1);
        chk("ovf_inflight_valid", eng_valid, 1);
        chk("ovf_inflight_op", eng_op, ENG_OP_SEED);
        chk("ovf_inflight_arg", eng_arg, 32'd1);
        send(CMD_IDLE, 32'd0);
        chk("abort_clears_ovf", overflow, 0);
        chk("abort_holds_valid", eng_valid, 1);
        eng_ready = 1'b1;
        tick(10);
        chk("abort_only_inflight", hs_cnt - h0, 1);
        chk("abort_last_op", last_op, ENG_OP_SEED);
        chk("abort_busy_end", busy, 0);
        chk("abort_gen_cleared", gen_count, 0);

        // ADVANCE 100 aborted after ten handshakes
        s0 = step_cnt;
        got = 1'b0;
        send(CMD_ADVANCE, 32'd100);
        for (int i = 0; i < 60 && !got; i++) begin
            tick(1);
            if ((step_cnt - s0) >= 10) got = 1'b1;
        end
        chk("adv100_reached_10", got, 1);
        send(CMD_IDLE, 32'd0);
        tick(6);
        chk("adv100_steps_le11", ((step_cnt - s0) <= 11), 1);
        chk("adv100_valid_end", eng_valid, 0);
        chk("adv100_busy_end", busy, 0);
        chk("adv100_gen_count", gen_count, GEN_EN ? (step_cnt - s0) : 0);

        // Asynchronous reset during a stalled ADVANCE
        eng_ready = 1'b0;
        send(CMD_ADVANCE, 32'd5);
        tick(3);
        chk("rst2_valid_before", eng_valid, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_vals("rst2");
        tick(2);
        chk_reset_vals("rst2_hold");
        reset_n = 1'b1;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
